// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: drives fetch/decode/execute/memory/writeback,
// bus handshakes, per-stage strobes, halt/error detection and retired/cycle counters.
module core_ctrl_fsm #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  func,
    input  logic [11:0] sys_imm,
    input  logic        branch_taken,
    output logic        if_req_valid,
    input  logic        if_req_ready,
    input  logic        if_resp_valid,
    input  logic        if_resp_err,
    output logic        mem_req_valid,
    output logic        mem_req_we,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic        mem_resp_err,
    output logic        inst_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic        error,
    output logic [3:0]  state,
    output logic [31:0] instret,
    output logic [31:0] cycles
);

    typedef enum logic [3:0] {
        RESET      = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXEC       = 4'd4,
        MEM_REQ    = 4'd5,
        MEM_WAIT   = 4'd6,
        WB         = 4'd7,
        HALT       = 4'd8,
        ERROR      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [7:0] TMO = 8'(BUS_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] tcnt;
    logic       br_q;
    logic       legal, is_ebreak, is_mem, timeout;

    assign legal     = op inside {OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_LOAD,
                                  OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM};
    assign is_ebreak = (op == OP_SYSTEM) && (func == 3'd0) && (sys_imm == 12'd1);
    assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign timeout   = (tcnt == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion wins over an expiring timeout; an error response and a timeout both land in ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:      state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (if_req_ready)  state_d = FETCH_WAIT;
                else if (timeout)  state_d = ERROR;
            end
            FETCH_WAIT: begin
                if (if_resp_valid) state_d = if_resp_err ? ERROR : DECODE;
                else if (timeout)  state_d = ERROR;
            end
            DECODE: begin
                if (!legal)         state_d = ERROR;
                else if (is_ebreak) state_d = HALT;
                else                state_d = EXEC;
            end
            EXEC:       state_d = is_mem ? MEM_REQ : WB;
            MEM_REQ: begin
                if (mem_req_ready) state_d = MEM_WAIT;
                else if (timeout)  state_d = ERROR;
            end
            MEM_WAIT: begin
                if (mem_resp_valid) state_d = mem_resp_err ? ERROR : WB;
                else if (timeout)   state_d = ERROR;
            end
            WB:         state_d = FETCH_REQ;
            HALT:       state_d = HALT;
            ERROR:      state_d = ERROR;
            default:    state_d = ERROR;
        endcase
    end

    always_comb begin
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        inst_we       = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        reg_we        = 1'b0;
        wb_sel        = 2'd0;
        case (state_q)
            FETCH_REQ:  if_req_valid = 1'b1;
            FETCH_WAIT: inst_we = if_resp_valid && !if_resp_err;
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = (op == OP_STORE);
            end
            WB: begin
                pc_we = 1'b1;
                if ((op == OP_JAL) || ((op == OP_BRANCH) && br_q)) pc_sel = 2'd1;
                else if (op == OP_JALR)                             pc_sel = 2'd2;
                reg_we = !(op inside {OP_STORE, OP_BRANCH, OP_SYSTEM});
                if (op == OP_LOAD)                          wb_sel = 2'd1;
                else if ((op == OP_JAL) || (op == OP_JALR)) wb_sel = 2'd2;
            end
            default: ;
        endcase
    end

    assign halt  = (state_q == HALT);
    assign error = (state_q == ERROR);
    assign state = state_q;

    // The states preceding each REQ entry (RESET, WB, EXEC) clear the timeout counter, so it
    // reads 0 in the first REQ cycle and keeps counting across the REQ->WAIT transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            br_q    <= 1'b0;
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (state_q inside {RESET, EXEC, WB}) begin
                tcnt <= '0;
            end else if (state_q inside {FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT}) begin
                tcnt <= tcnt + 8'd1;
            end
            if (state_q == EXEC) begin
                br_q <= branch_taken;
            end
            if (state_q == WB) begin
                instret <= instret + 32'd1;
            end
            if ((state_q != HALT) && (state_q != ERROR)) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

endmodule
